// File: rtl/mc14500b_program_loader.sv
// mc14500b_program_loader: packs a framed byte stream into 12-bit MC14500B program words, holding the CPU in reset while loading.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte that makes the frame sum to 8'h00.
module mc14500b_program_loader #(
    parameter int WRITE_GAP      = 1,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_rst,
    output logic        program_write,
    output logic [11:0] program_cmd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);
    typedef enum logic [3:0] {
        IDLE, LEN, HI, LO, WRITE, GAP,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        RELEASE, FAIL
    } state_t;

    state_t     state, next;
    logic [3:0] cnt;
    logic [8:0] n;
    logic [3:0] nib;
    logic       from_frame;
    logic       hs;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    localparam state_t AFTER_LAST = CSUM;
`else
    localparam state_t AFTER_LAST = RELEASE;
`endif

    assign hs            = in_valid & in_ready;
    assign busy          = state != IDLE;
    assign cpu_rst       = state != IDLE;
    assign program_write = state == WRITE;
`ifdef LOADER_CHECKSUM_EN
    assign in_ready      = state == LEN || state == HI || state == LO || state == CSUM;
`else
    assign in_ready      = state == LEN || state == HI || state == LO;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = load_start ? LEN : IDLE;
            LEN:     next = hs ? HI : LEN;
            HI:      next = !hs ? HI : (in_data[7:4] != 4'h0) ? FAIL : LO;
            LO:      next = hs ? WRITE : LO;
            WRITE:   next = GAP;
            GAP:     next = (cnt != 4'd1) ? GAP : (words_loaded < n) ? HI : AFTER_LAST;
`ifdef LOADER_CHECKSUM_EN
            CSUM:    next = !hs ? CSUM : (8'(sum + in_data) == 8'h00) ? RELEASE : FAIL;
`endif
            RELEASE: next = (cnt == 4'd1) ? IDLE : RELEASE;
            FAIL:    next = load_start ? LEN : FAIL;
            default: next = IDLE;
        endcase
    end

    // The FSM leaves reset in RELEASE so the CPU sees a clean reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RELEASE;
            cnt          <= 4'(RELEASE_CYCLES);
            n            <= 9'd0;
            nib          <= 4'h0;
            from_frame   <= 1'b0;
            program_cmd  <= 12'h000;
            words_loaded <= 9'd0;
            error        <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= next;
            if (next == GAP && state != GAP)
                cnt <= 4'(WRITE_GAP);
            else if (next == RELEASE && state != RELEASE)
                cnt <= 4'(RELEASE_CYCLES);
            else
                cnt <= cnt - 4'd1;
            if (next == RELEASE && state != RELEASE)
                from_frame <= 1'b1;
            else if (state == IDLE)
                from_frame <= 1'b0;
            done <= state == RELEASE && next == IDLE && from_frame;
            if ((state == IDLE || state == FAIL) && load_start) begin
                error        <= 1'b0;
                words_loaded <= 9'd0;
            end
            if (state == LEN && hs)
                n <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
            if (state == HI && hs) begin
                nib <= in_data[3:0];
                if (in_data[7:4] != 4'h0)
                    error <= 1'b1;
            end
            if (state == LO && hs)
                program_cmd <= {nib, in_data};
            if (state == WRITE)
                words_loaded <= words_loaded + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            if (state == CSUM && hs && 8'(sum + in_data) != 8'h00)
                error <= 1'b1;
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)
            sum <= 8'h00;
        else if (state == LEN && hs)
            sum <= in_data;
        else if ((state == HI || state == LO) && hs)
            sum <= sum + in_data;
    end
`endif
endmodule

// File: tb/tb_mc14500b_program_loader.sv
// tb_mc14500b_program_loader: randomized frame loads checked against an expected word list per frame.
module tb_mc14500b_program_loader;
    localparam int WG = 1;
    localparam int RC = 2;

    logic        clk = 0, rst = 1, load_start = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, cpu_rst, program_write, busy, done, error;
    logic [11:0] program_cmd;
    logic [8:0]  words_loaded;

    int errors = 0, checks = 0;
    int cyc = 0, done_cnt = 0, done_time = 0, viol = 0, since = 100;
    logic pw_d = 0;
    logic [11:0] writes[$];
    int wtimes[$];
    logic [11:0] nom[$] = '{12'h6FF, 12'hAFF, 12'hBFF, 12'h800, 12'h700,
                            12'h2FF, 12'h800, 12'h801, 12'h802, 12'hC04};

    mc14500b_program_loader #(.WRITE_GAP(WG), .RELEASE_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .cpu_rst(cpu_rst),
        .program_write(program_write), .program_cmd(program_cmd), .busy(busy),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Observe strobes, done pulses and stall rules between edges.
    always @(negedge clk) begin
        if (program_write) begin
            writes.push_back(program_cmd);
            wtimes.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_time = cyc;
        end
        if (program_write && (pw_d || !cpu_rst)) viol++;
        since = program_write ? 0 : (since < 100 ? since + 1 : since);
        if (in_ready && since <= WG) viol++;
        pw_d = program_write;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        load_start = 1;
        tick();
        load_start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t = 0;
        if (stall) repeat ($urandom_range(0, 3)) begin
            in_valid = 0;
            tick();
        end
        in_valid = 1;
        in_data  = b;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_idle;
        int t = 0;
        while (cpu_rst && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout: cpu_rst=%0b required 0", cpu_rst);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] w[$], input bit stall, input int csum_delta);
        logic [7:0] s, len;
        len = 8'(w.size());
        s   = len;
        pulse_start();
        checks++;
        if (error !== 0 || words_loaded !== 0 || in_ready !== 1 || cpu_rst !== 1 || busy !== 1) begin
            errors++;
            $display("FAIL start_state: err=%0b words=%0d rdy=%0b cpu_rst=%0b busy=%0b required 0 0 1 1 1",
                     error, words_loaded, in_ready, cpu_rst, busy);
        end
        send_byte(len, stall);
        foreach (w[i]) begin
            send_byte({4'h0, w[i][11:8]}, stall);
            send_byte(w[i][7:0], stall);
            checks++;
            if (program_write !== 1 || program_cmd !== w[i]) begin
                errors++;
                $display("FAIL write_latency word %0d: pw=%0b cmd=%03h required 1 %03h",
                         i, program_write, program_cmd, w[i]);
            end
            s = s + {4'h0, w[i][11:8]} + w[i][7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - s + 8'(csum_delta)), stall);
`else
        if (csum_delta != 0) $display("note: checksum disabled, delta %0d unused", csum_delta);
`endif
    endtask

    task automatic test_frame(input string name, input logic [11:0] w[$], input bit stall);
        int d0;
        bit bad;
        writes.delete();
        wtimes.delete();
        viol = 0;
        d0 = done_cnt;
        send_frame(w, stall, 0);
        wait_idle();
        bad = writes.size() != w.size();
        if (!bad) foreach (w[i]) if (writes[i] !== w[i]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s words: got %0d writes (first %03h) required %0d (first %03h)",
                     name, writes.size(), writes.size() ? writes[0] : 12'h0, w.size(), w[0]);
        end
        checks++;
        if (words_loaded !== 9'(w.size()) || error !== 0 || cpu_rst !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL %s final: words=%0d err=%0b cpu_rst=%0b busy=%0b required %0d 0 0 0",
                     name, words_loaded, error, cpu_rst, busy, w.size());
        end
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL %s done: pulses=%0d required 1", name, done_cnt - d0);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL %s protocol: violations=%0d required 0", name, viol);
        end
        if (!stall && !bad) begin
            for (int i = 1; i < wtimes.size(); i++) begin
                checks++;
                if (wtimes[i] - wtimes[i-1] !== 3 + WG) begin
                    errors++;
                    $display("FAIL %s period %0d: got %0d required %0d", name, i,
                             wtimes[i] - wtimes[i-1], 3 + WG);
                end
            end
`ifndef LOADER_CHECKSUM_EN
            checks++;
            if (done_time - wtimes[wtimes.size()-1] !== WG + RC + 1) begin
                errors++;
                $display("FAIL %s release: got %0d required %0d", name,
                         done_time - wtimes[wtimes.size()-1], WG + RC + 1);
            end
`endif
        end
    endtask

    task automatic test_reset;
        int n = 0;
        rst = 1;
        repeat (3) tick();
        checks++;
        if (cpu_rst !== 1 || program_write !== 0 || program_cmd !== 0 || in_ready !== 0 ||
            busy !== 1 || done !== 0 || error !== 0 || words_loaded !== 0) begin
            errors++;
            $display("FAIL reset_values: cpu_rst=%0b pw=%0b cmd=%03h rdy=%0b busy=%0b done=%0b err=%0b words=%0d",
                     cpu_rst, program_write, program_cmd, in_ready, busy, done, error, words_loaded);
        end
        rst = 0;
        while (cpu_rst && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n !== RC) begin
            errors++;
            $display("FAIL reset_release: cpu_rst cycles=%0d required %0d", n, RC);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt !== 0 || writes.size() !== 0) begin
            errors++;
            $display("FAIL reset_done: done=%0d writes=%0d required 0 0", done_cnt, writes.size());
        end
    endtask

    task automatic test_bad_nibble;
        writes.delete();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h06, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h1A, 0);
        repeat (3) tick();
        in_valid = 1;
        in_data  = 8'h00;
        repeat (5) tick();
        in_valid = 0;
        checks++;
        if (error !== 1 || cpu_rst !== 1 || in_ready !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL bad_nibble state: err=%0b cpu_rst=%0b rdy=%0b busy=%0b required 1 1 0 1",
                     error, cpu_rst, in_ready, busy);
        end
        checks++;
        if (writes.size() !== 1) begin
            errors++;
            $display("FAIL bad_nibble writes: got %0d required 1", writes.size());
        end
        test_frame("reload", nom, 0);
    endtask

    task automatic test_ignore_start;
        writes.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h05, 0);
        send_byte(8'h12, 0);
        pulse_start();
        send_byte(8'h09, 0);
        send_byte(8'h34, 0);
        wait_idle();
        checks++;
        if (writes.size() !== 2 || writes[0] !== 12'h512 || writes[1] !== 12'h934 || words_loaded !== 2) begin
            errors++;
            $display("FAIL ignore_start: writes=%0d words=%0d required 2 writes 512,934",
                     writes.size(), words_loaded);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum;
        int d0 = done_cnt;
        send_frame(nom, 0, 1);
        repeat (5) tick();
        checks++;
        if (error !== 1 || cpu_rst !== 1 || in_ready !== 0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL bad_checksum: err=%0b cpu_rst=%0b rdy=%0b done=%0d required 1 1 0 0",
                     error, cpu_rst, in_ready, done_cnt - d0);
        end
    endtask
`endif

    task automatic test_mid_reset;
        int d0;
        logic [11:0] one[$] = '{12'hC04};
        writes.delete();
        pulse_start();
        send_byte(8'h0A, 0);
        for (int i = 0; i < 4; i++) begin
            send_byte({4'h0, nom[i][11:8]}, 0);
            send_byte(nom[i][7:0], 0);
        end
        rst = 1;
        tick();
        checks++;
        if (cpu_rst !== 1 || program_write !== 0 || program_cmd !== 0 || in_ready !== 0 ||
            busy !== 1 || done !== 0 || error !== 0 || words_loaded !== 0) begin
            errors++;
            $display("FAIL mid_reset: cpu_rst=%0b pw=%0b cmd=%03h rdy=%0b busy=%0b done=%0b err=%0b words=%0d",
                     cpu_rst, program_write, program_cmd, in_ready, busy, done, error, words_loaded);
        end
        rst = 0;
        d0 = done_cnt;
        wait_idle();
        repeat (2) tick();
        checks++;
        if (done_cnt !== d0 || writes.size() !== 4) begin
            errors++;
            $display("FAIL mid_reset_after: done=%0d writes=%0d required 0 4", done_cnt - d0, writes.size());
        end
        test_frame("one_word", one, 0);
    endtask

    task automatic test_random;
        logic [11:0] w[$];
        for (int f = 0; f < 6; f++) begin
            w.delete();
            repeat ($urandom_range(1, 16)) w.push_back(12'($urandom));
            test_frame("random", w, 1);
        end
    endtask

    task automatic test_full_256;
        logic [11:0] w[$];
        repeat (256) w.push_back(12'($urandom));
        test_frame("len256", w, 0);
    endtask

    initial begin
        in_data = 0;
        test_reset();
        test_frame("nominal", nom, 0);
        test_frame("stalled", nom, 1);
        test_bad_nibble();
        test_ignore_start();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_mid_reset();
        test_random();
        test_full_256();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
